proc_clock_pause_ctrl: RTL and testbench

//  Run/halt/single-step controller for the processor clock. Drives the divider's
//  'locked' pause input and samples the divided clock (c0) fed back as proc_clk.

---
 rtl/proc_clock_pause_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_proc_clock_pause_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_clock_pause_ctrl.sv
// Run/halt/single-step controller for the divided processor clock (drives divider 'locked').
// Define PROC_BREAKPOINT_EN to include the PC breakpoint compare; otherwise pc/bp_* are ignored.
module proc_clock_pause_ctrl #(
  parameter bit START_HALTED    = 1'b0,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 32
) (
  input  logic             inclk0,
  input  logic             reset,
  input  logic             proc_clk,
  input  logic             run_btn,
  input  logic             halt_btn,
  input  logic             step_btn,
  input  logic [31:0]      pc,
  input  logic [31:0]      bp_addr,
  input  logic             bp_valid,
  output logic             locked,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int BTN_RUN  = 0;
  localparam int BTN_HALT = 1;
  localparam int BTN_STEP = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  localparam state_t RESET_STATE = START_HALTED ? ST_HALTED : ST_RUN;

  logic [2:0] btn_raw;
  logic [2:0] btn_req;

  assign btn_raw = {step_btn, halt_btn, run_btn};

  // Per button: synchroniser, debounce (counter restarts whenever the synced level
  // returns to the accepted level), then a one-cycle request on the accepted rising edge.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic [1:0]      sync_q, sync_d;
      logic [DB_W-1:0] cnt_q, cnt_d;
      logic            level_q, level_d;
      logic            prev_q, prev_d;

      always_comb begin
        sync_d  = {sync_q[0], btn_raw[gi]};
        cnt_d   = '0;
        level_d = level_q;
        prev_d  = level_q;
        if (sync_q[1] != level_q) begin
          if (cnt_q == DB_LAST) begin
            level_d = sync_q[1];
          end else begin
            cnt_d = cnt_q + DB_W'(1);
          end
        end
      end

      always_ff @(posedge inclk0 or posedge reset) begin
        if (reset) begin
          sync_q  <= '0;
          cnt_q   <= '0;
          level_q <= 1'b0;
          prev_q  <= 1'b0;
        end else begin
          sync_q  <= sync_d;
          cnt_q   <= cnt_d;
          level_q <= level_d;
          prev_q  <= prev_d;
        end
      end

      assign btn_req[gi] = level_q & ~prev_q;
    end
  endgenerate

  logic run_req, halt_req, step_req;

  assign run_req  = btn_req[BTN_RUN];
  assign halt_req = btn_req[BTN_HALT];
  assign step_req = btn_req[BTN_STEP];

  logic [1:0] psync_q, psync_d;
  logic       pprev_q, pprev_d;
  logic       proc_rise;

  always_comb begin
    psync_d = {psync_q[0], proc_clk};
    pprev_d = psync_q[1];
  end

  assign proc_rise = psync_q[1] & ~pprev_q;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (proc_rise) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // PC only changes on proc_clk rises, so it is settled by the time proc_rise is seen.
  logic bp_match;
`ifdef PROC_BREAKPOINT_EN
  assign bp_match = bp_valid && (pc == bp_addr);
`else
  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{pc, bp_addr, bp_valid};
  assign bp_match         = 1'b0;
`endif

  state_t state_q, state_d;
  logic   bp_hit_q, bp_hit_d;
  logic   locked_q, locked_d;
  logic   halted_q, halted_d;

  always_comb begin
    state_d  = state_q;
    bp_hit_d = bp_hit_q;
    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALTED;
        end else if (proc_rise && bp_match) begin
          state_d  = ST_HALTED;
          bp_hit_d = 1'b1;
        end
      end
      ST_HALTED: begin
        if (!halt_req) begin
          if (run_req) begin
            state_d  = ST_RUN;
            bp_hit_d = 1'b0;
          end else if (step_req) begin
            state_d  = ST_STEP;
            bp_hit_d = 1'b0;
          end
        end
      end
      ST_STEP: begin
        if (halt_req) begin
          state_d = ST_HALTED;
        end else if (run_req) begin
          state_d = ST_RUN;
        end else if (proc_rise) begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
    locked_d = (state_d == ST_HALTED);
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge inclk0 or posedge reset) begin
    if (reset) begin
      psync_q  <= '0;
      pprev_q  <= 1'b0;
      count_q  <= '0;
      state_q  <= RESET_STATE;
      bp_hit_q <= 1'b0;
      locked_q <= START_HALTED;
      halted_q <= START_HALTED;
    end else begin
      psync_q  <= psync_d;
      pprev_q  <= pprev_d;
      count_q  <= count_d;
      state_q  <= state_d;
      bp_hit_q <= bp_hit_d;
      locked_q <= locked_d;
      halted_q <= halted_d;
    end
  end

  assign locked      = locked_q;
  assign halted      = halted_q;
  assign bp_hit      = bp_hit_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_proc_clock_pause_ctrl.sv
// Bench for proc_clock_pause_ctrl: a pausable divider model produces proc_clk and pc,
// buttons are pressed/bounced with randomized timing, outputs checked against the model.
module tb_proc_clock_pause_ctrl;

  localparam int HALF = 20;

  logic        inclk0 = 1'b0;
  logic        reset = 1'b0;
  logic        proc_clk;
  logic        run_btn = 1'b0;
  logic        halt_btn = 1'b0;
  logic        step_btn = 1'b0;
  logic [31:0] pc;
  logic [31:0] bp_addr = 32'h0;
  logic        bp_valid = 1'b0;
  logic        locked;
  logic        halted;
  logic        bp_hit;
  logic [31:0] cycle_count;

  int          tests = 0;
  int          fails = 0;
  int unsigned model_rises;
  int          div_cnt;

  proc_clock_pause_ctrl #(
    .START_HALTED   (1'b0),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (32)
  ) dut (
    .inclk0     (inclk0),
    .reset      (reset),
    .proc_clk   (proc_clk),
    .run_btn    (run_btn),
    .halt_btn   (halt_btn),
    .step_btn   (step_btn),
    .pc         (pc),
    .bp_addr    (bp_addr),
    .bp_valid   (bp_valid),
    .locked     (locked),
    .halted     (halted),
    .bp_hit     (bp_hit),
    .cycle_count(cycle_count)
  );

  always #5 inclk0 = ~inclk0;

  // Divider model: toggles every HALF cycles while unlocked; pc = number of rises so far.
  always @(posedge inclk0) begin
    if (reset) begin
      div_cnt     <= 0;
      proc_clk    <= 1'b0;
      model_rises <= 0;
      pc          <= 32'h0;
    end else if (!locked) begin
      if (div_cnt == HALF - 1) begin
        div_cnt  <= 0;
        proc_clk <= ~proc_clk;
        if (!proc_clk) begin
          model_rises <= model_rises + 1;
          pc          <= model_rises + 1;
        end
      end else begin
        div_cnt <= div_cnt + 1;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge inclk0);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input string what);
    $display("[TB] t=%0t %s rises=%0d count=%0d locked=%0b halted=%0b bp_hit=%0b",
             $time, what, model_rises, cycle_count, locked, halted, bp_hit);
  endtask

  task automatic set_btn(input int which, input logic val);
    case (which)
      0: run_btn = val;
      1: halt_btn = val;
      default: step_btn = val;
    endcase
  endtask

  task automatic press(input int which, input int hold, input int settle);
    set_btn(which, 1'b1);
    tick(hold);
    set_btn(which, 1'b0);
    tick(settle);
  endtask

  task automatic wait_halted(input logic val, input int budget, input string tag);
    int n;
    n = 0;
    while (halted !== val && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 64'(halted), 64'(val));
  endtask

  task automatic wait_rises(input int unsigned target, input int budget, input string tag);
    int n;
    n = 0;
    while (model_rises < target && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 64'(model_rises >= target), 64'd1);
  endtask

  // One single step from HALTED with a random bounce prefix; exactly one rise must pass.
  task automatic do_step(input bit bounce, input string tag);
    int unsigned base;
    base = model_rises;
    if (bounce) begin
      for (int b = 0; b < 3; b++) begin
        press(2, $urandom_range(1, 3), $urandom_range(1, 2));
      end
    end
    step_btn = 1'b1;
    wait_halted(1'b0, 30, {tag, "_enter"});
    tick($urandom_range(0, 10));
    step_btn = 1'b0;
    wait_halted(1'b1, 200, {tag, "_relock"});
    tick(10);
    check({tag, "_count"}, 64'(cycle_count), 64'(base + 1));
    check({tag, "_locked"}, 64'(locked), 64'd1);
    txn(tag);
  endtask

  initial begin
    int          seen;
    int unsigned frozen;
    int          glen;

    #2 reset = 1'b1;
    tick(3);
    check("reset_locked", 64'(locked), 64'd0);
    check("reset_halted", 64'(halted), 64'd0);
    check("reset_bp_hit", 64'(bp_hit), 64'd0);
    check("reset_count", 64'(cycle_count), 64'd0);
    reset = 1'b0;
    txn("reset released");

    wait_rises(10, 1000, "run10_wait");
    tick(6);
    check("run10_locked", 64'(locked), 64'd0);
    check("run10_halted", 64'(halted), 64'd0);
    check("run10_count", 64'(cycle_count), 64'd10);

    wait_rises(model_rises + $urandom_range(1, 4), 400, "run_more_wait");
    tick(6);
    check("run_more_count", 64'(cycle_count), 64'(model_rises));
    txn("free run");

    // Halt held 50 cycles: lock must appear within 8 cycles of the press.
    halt_btn = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (locked === 1'b1) seen = 1;
    end
    check("halt_lock_within_8", 64'(seen), 64'd1);
    tick(42);
    halt_btn = 1'b0;
    tick(15);
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_count", 64'(cycle_count), 64'(model_rises));
    frozen = model_rises;
    tick(100);
    check("halt_frozen", 64'(cycle_count), 64'(frozen));
    txn("halt");

    do_step(1'b0, "step1");
    do_step(1'b0, "step2");
    do_step(1'b1, "step3_bounce");
    check("steps_halted", 64'(halted), 64'd1);

    press(0, $urandom_range(6, 20), 12);
    check("run_halted", 64'(halted), 64'd0);
    check("run_locked", 64'(locked), 64'd0);
    txn("run");

    halt_btn = 1'b1;
    run_btn  = 1'b1;
    tick(10);
    halt_btn = 1'b0;
    run_btn  = 1'b0;
    tick(12);
    check("halt_run_in_run", 64'(halted), 64'd1);
    txn("halt+run from RUN");

    halt_btn = 1'b1;
    run_btn  = 1'b1;
    tick(10);
    halt_btn = 1'b0;
    run_btn  = 1'b0;
    tick(12);
    check("halt_run_in_halted", 64'(halted), 64'd1);
    txn("halt+run from HALTED");

    for (int i = 0; i < 3; i++) begin
      glen = (i == 0) ? 3 : $urandom_range(1, 3);
      press(0, glen, 12);
      check("glitch_no_run", 64'(halted), 64'd1);
      txn("run glitch");
    end

    bp_addr  = model_rises + $urandom_range(2, 5);
    bp_valid = 1'b1;
    press(0, 8, 0);
`ifdef PROC_BREAKPOINT_EN
    wait_halted(1'b1, 400, "bp_halt_wait");
    tick(6);
    check("bp_halted", 64'(halted), 64'd1);
    check("bp_hit_set", 64'(bp_hit), 64'd1);
    check("bp_count", 64'(cycle_count), 64'(bp_addr));
    txn("breakpoint hit");
    press(0, 8, 10);
    check("bp_resume_hit", 64'(bp_hit), 64'd0);
    check("bp_resume_halted", 64'(halted), 64'd0);
    wait_rises(bp_addr + 2, 400, "bp_after_wait");
    tick(6);
    check("bp_no_rehit", 64'(halted), 64'd0);
`else
    wait_rises(bp_addr + 2, 400, "nobp_wait");
    tick(6);
    check("nobp_halted", 64'(halted), 64'd0);
    check("nobp_hit", 64'(bp_hit), 64'd0);
    check("nobp_count", 64'(cycle_count), 64'(model_rises));
`endif
    bp_valid = 1'b0;
    txn("breakpoint phase");

    // Reset while a halt press is still being debounced: the press must be lost.
    halt_btn = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(2);
    halt_btn = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(20);
    check("rst_debounce_halted", 64'(halted), 64'd0);
    txn("reset mid-debounce");

    press(1, 8, 12);
    check("pre_step_halted", 64'(halted), 64'd1);
    step_btn = 1'b1;
    wait_halted(1'b0, 30, "rst_step_enter");
    tick(2);
    reset = 1'b1;
    tick(1);
    check("rst_step_locked", 64'(locked), 64'd0);
    check("rst_step_count", 64'(cycle_count), 64'd0);
    step_btn = 1'b0;
    reset = 1'b0;
    tick(1);
    check("rst_step_run", 64'(halted), 64'd0);
    wait_rises(2, 200, "rst_step_rises");
    tick(6);
    check("rst_step_run_count", 64'(cycle_count), 64'(model_rises));
    check("rst_step_unlocked", 64'(locked), 64'd0);
    txn("reset mid-step");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
